// File: rtl/sine_wave_gen_pkg.sv
// Shared constants, types and the quarter-wave magnitude table for the
// sine_wave_gen lookup-table oscillator.
package sine_wave_gen_pkg;

  localparam int unsigned PHASE_W   = 8;
  localparam int unsigned SAMPLE_W  = 11;
  localparam int unsigned MAG_W     = 10;
  localparam int unsigned MIDSCALE  = 1024;
  localparam int unsigned LUT_DEPTH = 65;
  localparam int unsigned ROM_IDX_W = 7;

  // Quadrant of the wave selected by the top two phase bits.
  typedef enum logic [1:0] {
    QUAD_RISE    = 2'd0,  // 0..90 deg: +Q[o]
    QUAD_FALL    = 2'd1,  // 90..180 deg: +Q[64-o]
    QUAD_DIP     = 2'd2,  // 180..270 deg: -Q[o]
    QUAD_RECOVER = 2'd3   // 270..360 deg: -Q[64-o]
  } quadrant_t;

  // Magnitude plus sign, the state carried between pipeline stages.
  typedef struct packed {
    logic             neg;
    logic [MAG_W-1:0] mag;
  } mag_sign_t;

  // Q[k] = round(1023 * sin(2*pi*k/256)), k = 0..64.
  localparam logic [MAG_W-1:0] QUARTER_LUT [0:LUT_DEPTH-1] = '{
    10'd0,    10'd25,   10'd50,   10'd75,   10'd100,  10'd125,  10'd150,  10'd175,
    10'd200,  10'd224,  10'd249,  10'd273,  10'd297,  10'd321,  10'd345,  10'd368,
    10'd391,  10'd415,  10'd437,  10'd460,  10'd482,  10'd504,  10'd526,  10'd547,
    10'd568,  10'd589,  10'd609,  10'd629,  10'd649,  10'd668,  10'd687,  10'd705,
    10'd723,  10'd741,  10'd758,  10'd775,  10'd791,  10'd806,  10'd822,  10'd836,
    10'd851,  10'd864,  10'd877,  10'd890,  10'd902,  10'd914,  10'd925,  10'd935,
    10'd945,  10'd954,  10'd963,  10'd971,  10'd979,  10'd986,  10'd992,  10'd998,
    10'd1003, 10'd1008, 10'd1012, 10'd1015, 10'd1018, 10'd1020, 10'd1022, 10'd1023,
    10'd1023
  };

  // Offset-binary sample: midscale plus or minus the magnitude.
  // 1024 + 1023 = 2047 and 1024 - 1023 = 1, so 11 bits never overflow.
  function automatic logic [SAMPLE_W-1:0] apply_sign(input mag_sign_t ms);
    logic [SAMPLE_W-1:0] mid;
    logic [SAMPLE_W-1:0] mag_ext;
    mid     = SAMPLE_W'(MIDSCALE);
    mag_ext = {1'b0, ms.mag};
    return ms.neg ? (mid - mag_ext) : (mid + mag_ext);
  endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// Combinational quarter-wave magnitude ROM. Indices beyond the table
// (65..127) are unreachable from the top level and read as zero.
module sine_quarter_rom
  import sine_wave_gen_pkg::*;
(
  input  logic [ROM_IDX_W-1:0] idx_i,
  output logic [MAG_W-1:0]     mag_o
);

  // Table read with a defined value for out-of-range indices.
  always_comb begin
    mag_o = '0;
    if (idx_i < ROM_IDX_W'(LUT_DEPTH)) begin
      mag_o = QUARTER_LUT[idx_i];
    end
  end

endmodule

// File: rtl/sine_wave_gen.sv
// Lookup-table sine generator: 8-bit phase in, 11-bit offset-binary sample
// out, registered. Quadrant decode folds the phase onto a quarter-wave ROM.
// Build option SINE_WAVE_GEN_OUTPUT_REG_EN adds a magnitude/sign register
// ahead of the output register (latency 2 instead of 1).
module sine_wave_gen
  import sine_wave_gen_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [PHASE_W-1:0]  period,
  output logic [SAMPLE_W-1:0] sine
);

  quadrant_t            quad;
  logic [5:0]           offset;
  logic [ROM_IDX_W-1:0] rom_idx;
  logic [MAG_W-1:0]     rom_mag;
  mag_sign_t            cur;
  logic [SAMPLE_W-1:0]  sine_d;
  logic [SAMPLE_W-1:0]  sine_q;

  // Quadrant decode and mirror index; 64-o is 7 bits so o=0 reaches Q[64].
  always_comb begin
    quad    = quadrant_t'(period[PHASE_W-1 -: 2]);
    offset  = period[5:0];
    rom_idx = {1'b0, offset};
    case (quad)
      QUAD_FALL, QUAD_RECOVER: rom_idx = ROM_IDX_W'(LUT_DEPTH - 1) - {1'b0, offset};
      default:                 rom_idx = {1'b0, offset};
    endcase
  end

  sine_quarter_rom u_rom (
    .idx_i (rom_idx),
    .mag_o (rom_mag)
  );

  // Sign comes straight from the upper half of the phase circle.
  always_comb begin
    cur     = '0;
    cur.neg = period[PHASE_W-1];
    cur.mag = rom_mag;
  end

`ifdef SINE_WAVE_GEN_OUTPUT_REG_EN
  mag_sign_t s1_d;
  mag_sign_t s1_q;

  // Stage 1 input is the decoded magnitude and sign.
  always_comb begin
    s1_d = cur;
  end

  // Stage 1 register; reset to m=0, sign=0 so stage 2 yields midscale.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
    end else begin
      s1_q <= s1_d;
    end
  end

  // Stage 2 combinational: apply sign and midscale offset.
  always_comb begin
    sine_d = apply_sign(s1_q);
  end
`else
  // Single stage: ROM, sign and offset all ahead of the output register.
  always_comb begin
    sine_d = apply_sign(cur);
  end
`endif

  // Output sample register; reset holds the phase-0 value (midscale).
  always_ff @(posedge clk) begin
    if (rst) begin
      sine_q <= SAMPLE_W'(MIDSCALE);
    end else begin
      sine_q <= sine_d;
    end
  end

  assign sine = sine_q;

endmodule

// File: tb/tb_sine_wave_gen.sv
// Self-checking bench for sine_wave_gen: directed points, full sweeps with
// symmetry check, and random phase with random reset pulses.
module tb_sine_wave_gen;

`ifdef SINE_WAVE_GEN_OUTPUT_REG_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 1;
`endif

  localparam real PI = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  period = 8'd0;
  logic [10:0] sine;

  int n_checks = 0;
  int n_errors = 0;

  int exp_pipe [LAT];
  int ph_pipe  [LAT];
  bit vld_pipe [LAT];

  int sweep_obs  [256];
  bit sweep_seen [256];

  sine_wave_gen dut (
    .clk    (clk),
    .rst    (rst),
    .period (period),
    .sine   (sine)
  );

  always #5 clk = ~clk;

  function automatic int model_sine(input int p);
    real s;
    s = 1023.0 * $sin(2.0 * PI * p / 256.0);
    if (s >= 0.0) return 1024 + $rtoi(s + 0.5);
    else          return 1024 - $rtoi(-s + 0.5);
  endfunction

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle, advance the reference pipeline, settle past the edge.
  task automatic tick(input logic [7:0] p, input logic r);
    period = p;
    rst    = r;
    @(posedge clk);
    if (r) begin
      for (int unsigned i = 0; i < LAT; i++) begin
        exp_pipe[i] = 1024;
        vld_pipe[i] = 1'b0;
        ph_pipe[i]  = 0;
      end
    end else begin
      for (int unsigned i = LAT - 1; i > 0; i--) begin
        exp_pipe[i] = exp_pipe[i-1];
        ph_pipe[i]  = ph_pipe[i-1];
        vld_pipe[i] = vld_pipe[i-1];
      end
      exp_pipe[0] = model_sine(int'(p));
      ph_pipe[0]  = int'(p);
      vld_pipe[0] = 1'b1;
    end
    #1;
  endtask

  int dir_p   [13] = '{0, 64, 128, 192, 32, 96, 160, 224, 16, 1, 255, 63, 65};
  int dir_exp [13] = '{1024, 2047, 1024, 1, 1747, 1747, 301, 301, 1415, 1049, 999, 2047, 2047};

  initial begin
    for (int unsigned i = 0; i < 256; i++) begin
      sweep_obs[i]  = 0;
      sweep_seen[i] = 1'b0;
    end

    // Reset held three cycles with a full-scale phase present.
    for (int unsigned i = 0; i < 3; i++) begin
      tick(8'd64, 1'b1);
      check_eq($sformatf("reset hold %0d", i), int'(sine), 1024);
    end
    for (int unsigned i = 0; i < LAT; i++) begin
      tick(8'd64, 1'b0);
      check_eq($sformatf("release step %0d", i), int'(sine), exp_pipe[LAT-1]);
    end
    check_eq("release peak", int'(sine), 2047);

    // Directed points with hand-computed values.
    for (int unsigned k = 0; k < 13; k++) begin
      for (int unsigned i = 0; i < LAT; i++) tick(8'(dir_p[k]), 1'b0);
      check_eq($sformatf("dir p=%0d", dir_p[k]), int'(sine), dir_exp[k]);
    end

    // Two continuous sweeps, one step per cycle, plus flush.
    for (int unsigned pass = 0; pass < 2; pass++) begin
      for (int unsigned p = 0; p < 256; p++) begin
        tick(8'(p), 1'b0);
        check_eq($sformatf("sweep p=%0d", ph_pipe[LAT-1]), int'(sine), exp_pipe[LAT-1]);
        if (vld_pipe[LAT-1]) begin
          sweep_obs[ph_pipe[LAT-1]]  = int'(sine);
          sweep_seen[ph_pipe[LAT-1]] = 1'b1;
        end
      end
    end
    for (int unsigned i = 0; i < LAT; i++) begin
      tick(8'd0, 1'b0);
      if (vld_pipe[LAT-1]) begin
        sweep_obs[ph_pipe[LAT-1]]  = int'(sine);
        sweep_seen[ph_pipe[LAT-1]] = 1'b1;
      end
    end
    for (int unsigned p = 0; p < 128; p++) begin
      check_eq($sformatf("seen p=%0d", p), int'(sweep_seen[p] & sweep_seen[p+128]), 1);
      check_eq($sformatf("symmetry p=%0d", p), sweep_obs[p] + sweep_obs[p+128], 2048);
    end

    // Random phase with occasional single-cycle reset pulses.
    for (int unsigned i = 0; i < 1000; i++) begin
      logic [7:0] rp;
      logic       rr;
      rp = 8'($urandom_range(0, 255));
      rr = ($urandom_range(0, 19) == 0);
      tick(rp, rr);
      if (rr) check_eq($sformatf("rand rst %0d", i), int'(sine), 1024);
      else    check_eq($sformatf("rand %0d", i), int'(sine), exp_pipe[LAT-1]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
